tick_bcd_timer: RTL and testbench
=================================

// Module: tick_bcd_timer
// PURPOSE
//  Programmable BCD countdown timer downstream of the cont_1s_RCO prescaler.
//  Consumes the prescaler's one-cycle RCO pulse as a count enable; decrements
//  an NDIGITS BCD value once per enable while running.
//  Signals expiry with a one-cycle done pulse and presents the digits for the
//  display/mux stage.
// PARAMETERS
//  NDIGITS      4   number of BCD digits; count width = 4*NDIGITS
//  AUTO_RELOAD  0   1: on expiry reload preset and keep running; 0: stop in DONE
// PORTS
//  mclk     in   1          system clock, all logic on posedge
//  reset    in   1          synchronous, active-high
//  tick_en  in   1          count enable, 1-cycle pulse from prescaler RCO
//  load     in   1          capture preset into count and preset register
//  preset   in   4*NDIGITS  BCD preset, digit 0 = LSD in bits [3:0]
//  start    in   1          level/pulse: begin or resume counting
//  stop     in   1          level/pulse: pause counting
//  digits   out  4*NDIGITS  current BCD count (registered)
//  running  out  1          1 while state == RUN
//  zero     out  1          1 while count == 0 (combinational from count reg)
//  done     out  1          1-cycle pulse on expiry (registered)
// BEHAVIOUR
//  Reset (sampled on mclk): state=IDLE, count=0, preset reg=0, done=0,
//   running=0, zero=1.
//  States: IDLE, RUN, PAUSE, DONE. Priority per cycle:
//   reset > load > stop > start > tick_en.
//  load (any state): count<=preset, preset reg<=preset, state->IDLE, done=0.
//   Any preset digit >9 is clamped to 9 on capture.
//  IDLE: start & count!=0 -> RUN. start with count==0 ignored (stay IDLE).
//  RUN: stop -> PAUSE, no decrement that cycle.
//   tick_en & !stop: count <= count-1 (BCD: digit 0 -> 9, borrow to next digit).
//   If that decrement takes count 1 -> 0: done=1 the next cycle;
//   AUTO_RELOAD=0 -> DONE, count holds 0;
//   AUTO_RELOAD=1 -> count<=preset reg (0 -> 0 skipped), stays RUN, done pulses.
//   If AUTO_RELOAD=1 and preset reg==0: -> DONE.
//  PAUSE: count frozen, tick_en ignored. start & !stop -> RUN.
//  DONE: count frozen at 0, start ignored; leave only by load or reset.
//  start and tick_en in the same cycle from IDLE/PAUSE: transition to RUN only;
//   the tick is not consumed (first decrement on the next tick_en).
//  start and stop together: stop wins.
//  Latency: tick_en in RUN at edge N -> digits updated after edge N.
//   done is high for exactly the cycle after the expiring edge.
//  running mirrors state==RUN, registered with state.
//  No count below 0; no wrap from 0 to all-9s under any input sequence.
//  Reset mid-count: all state cleared on that edge regardless of other inputs.
// TESTING
//  T1: reset -> digits=0000, zero=1, running=0, done=0; start ignored.
//  T2: load 0012, start, 12 tick_en pulses -> digits 0011..0000,
//      done high 1 cycle after 12th tick, state DONE, running=0.
//  T3: BCD borrow: load 1000, run, 1 tick -> 0999; load 0100, 1 tick -> 0099.
//  T4: stop after 3 ticks from 0050 -> 0047 frozen through 5 ticks;
//      start -> resumes 0046 on next tick.
//      start+stop same cycle -> stays PAUSE.
//  T5: start coincident with tick_en from IDLE at 0005 -> no decrement;
//      next tick -> 0004.
//      load 00F3 -> digits 0093 (clamp).
//  T6: AUTO_RELOAD=1, preset 0003: 3 ticks -> done pulse, digits 0003,
//      running stays 1.
//      Reset asserted mid-run -> 0000/IDLE on that edge.

Source files
------------

// File: rtl/tick_bcd_timer.sv
// rtl/tick_bcd_timer.sv - programmable BCD countdown timer driven by a prescaler tick enable
// Counts down once per tick_en while running; one-cycle done pulse on expiry.
module tick_bcd_timer #(
  parameter int NDIGITS     = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                 mclk,
  input  logic                 reset,
  input  logic                 tick_en,
  input  logic                 load,
  input  logic [4*NDIGITS-1:0] preset,
  input  logic                 start,
  input  logic                 stop,
  output logic [4*NDIGITS-1:0] digits,
  output logic                 running,
  output logic                 zero,
  output logic                 done
);

  localparam int W = 4 * NDIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_count;
  logic [W-1:0]   r_preset;
  logic           r_running;
  logic           r_done;

  logic [W-1:0]   w_dec;
  logic [W-1:0]   w_clamped;
  logic           w_last;
  logic           w_borrow;

  // Ripple-borrow BCD decrement; only used when count is nonzero.
  always_comb begin
    w_dec    = r_count;
    w_borrow = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (w_borrow) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          w_borrow        = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_clamped = preset;
    for (int i = 0; i < NDIGITS; i++) begin
      if (preset[4*i +: 4] > 4'd9) w_clamped[4*i +: 4] = 4'd9;
    end
  end

  assign w_last = (r_count == W'(1));

  always_ff @(posedge mclk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_preset  <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_count   <= w_clamped;
        r_preset  <= w_clamped;
        r_state   <= S_IDLE;
        r_running <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!stop && start && r_count != '0) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
          S_RUN: begin
            if (stop) begin
              r_state   <= S_PAUSE;
              r_running <= 1'b0;
            end else if (tick_en && r_count != '0) begin
              if (w_last) begin
                r_done <= 1'b1;
                if (AUTO_RELOAD && r_preset != '0) begin
                  r_count <= r_preset;
                end else begin
                  r_count   <= '0;
                  r_state   <= S_DONE;
                  r_running <= 1'b0;
                end
              end else begin
                r_count <= w_dec;
              end
            end
          end
          S_PAUSE: begin
            if (start && !stop) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
          default: begin
            r_state   <= S_DONE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign digits  = r_count;
  assign running = r_running;
  assign zero    = (r_count == '0);
  assign done    = r_done;

endmodule

// File: tb/tb_tick_bcd_timer.sv
// tb/tb_tick_bcd_timer.sv - scoreboard bench for tick_bcd_timer (one-shot and auto-reload instances)
module tb_tick_bcd_timer;

  logic        mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic        reset, tick_en, load, start, stop;
  logic [15:0] preset;
  logic [15:0] digits;
  logic        running, zero, done;

  logic        b_reset, b_tick_en, b_load, b_start, b_stop;
  logic [15:0] b_preset;
  logic [15:0] b_digits;
  logic        b_running, b_zero, b_done;

  tick_bcd_timer #(.NDIGITS(4), .AUTO_RELOAD(1'b0)) dut (
    .mclk(mclk), .reset(reset), .tick_en(tick_en), .load(load),
    .preset(preset), .start(start), .stop(stop),
    .digits(digits), .running(running), .zero(zero), .done(done)
  );

  tick_bcd_timer #(.NDIGITS(4), .AUTO_RELOAD(1'b1)) dut_ar (
    .mclk(mclk), .reset(b_reset), .tick_en(b_tick_en), .load(b_load),
    .preset(b_preset), .start(b_start), .stop(b_stop),
    .digits(b_digits), .running(b_running), .zero(b_zero), .done(b_done)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_d;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic cyc();
    @(posedge mclk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; preset = v; cyc(); load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_tick();
    tick_en = 1'b1; cyc(); tick_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; cyc(); reset = 1'b0;
    cyc(); start = 1'b0;
    n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL reset_digits got %h want 0000", digits); end
    n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL reset_zero got %b want 1", zero); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running got %b want 0", running); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_countdown();
    do_load(16'h0012);
    do_start();
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL cd_running got %b want 1", running); end
    for (int i = 11; i >= 0; i--) begin
      exp_q.push_back(to_bcd(i));
      do_tick();
      exp_d = exp_q.pop_front();
      n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL cd_digits got %h want %h", digits, exp_d); end
      n_cmp++; if (done !== (i == 0)) begin n_bad++; $display("FAIL cd_done at %0d got %b want %b", i, done, i == 0); end
      if (i != 0) cyc();
    end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL cd_running_end got %b want 0", running); end
    cyc();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL cd_done_width got %b want 0", done); end
    start = 1'b1; tick_en = 1'b1; cyc(); cyc(); start = 1'b0; tick_en = 1'b0;
    n_cmp++; if (digits !== 16'h0000 || running !== 1'b0 || zero !== 1'b1) begin
      n_bad++; $display("FAIL done_hold got %h run %b zero %b want 0000 0 1", digits, running, zero);
    end
  endtask

  task automatic test_borrow();
    do_load(16'h1000); do_start();
    exp_q.push_back(16'h0999); do_tick(); exp_d = exp_q.pop_front();
    n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL borrow_1000 got %h want %h", digits, exp_d); end
    do_load(16'h0100); do_start();
    exp_q.push_back(16'h0099); do_tick(); exp_d = exp_q.pop_front();
    n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL borrow_0100 got %h want %h", digits, exp_d); end
  endtask

  task automatic test_pause();
    do_load(16'h0050); do_start();
    for (int i = 49; i >= 47; i--) begin
      exp_q.push_back(to_bcd(i)); do_tick(); exp_d = exp_q.pop_front();
      n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL pause_pre got %h want %h", digits, exp_d); end
    end
    stop = 1'b1; tick_en = 1'b1; cyc(); stop = 1'b0; tick_en = 1'b0;
    n_cmp++; if (running !== 1'b0 || digits !== 16'h0047) begin
      n_bad++; $display("FAIL pause_enter run %b digits %h want 0 0047", running, digits);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(16'h0047); do_tick(); exp_d = exp_q.pop_front();
      n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL pause_frozen got %h want %h", digits, exp_d); end
    end
    do_start();
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL pause_resume got %b want 1", running); end
    exp_q.push_back(16'h0046); do_tick(); exp_d = exp_q.pop_front();
    n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL pause_after got %h want %h", digits, exp_d); end
    stop = 1'b1; cyc(); stop = 1'b0;
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL start_stop got %b want 0", running); end
    exp_q.push_back(16'h0046); do_tick(); exp_d = exp_q.pop_front();
    n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL start_stop_frozen got %h want %h", digits, exp_d); end
  endtask

  task automatic test_start_tick();
    do_load(16'h0005);
    start = 1'b1; tick_en = 1'b1; cyc(); start = 1'b0; tick_en = 1'b0;
    n_cmp++; if (digits !== 16'h0005 || running !== 1'b1) begin
      n_bad++; $display("FAIL start_tick digits %h run %b want 0005 1", digits, running);
    end
    exp_q.push_back(16'h0004); do_tick(); exp_d = exp_q.pop_front();
    n_cmp++; if (digits !== exp_d) begin n_bad++; $display("FAIL start_tick_next got %h want %h", digits, exp_d); end
    do_load(16'h00F3);
    n_cmp++; if (digits !== 16'h0093 || running !== 1'b0) begin
      n_bad++; $display("FAIL clamp_00F3 got %h run %b want 0093 0", digits, running);
    end
    do_load(16'hFA3C);
    n_cmp++; if (digits !== 16'h9939) begin n_bad++; $display("FAIL clamp_FA3C got %h want 9939", digits); end
  endtask

  task automatic test_auto_reload();
    b_load = 1'b1; b_preset = 16'h0003; cyc(); b_load = 1'b0;
    b_start = 1'b1; cyc(); b_start = 1'b0;
    exp_q.push_back(16'h0002); exp_q.push_back(16'h0001); exp_q.push_back(16'h0003);
    exp_q.push_back(16'h0002);
    for (int i = 0; i < 4; i++) begin
      b_tick_en = 1'b1; cyc(); b_tick_en = 1'b0;
      exp_d = exp_q.pop_front();
      n_cmp++; if (b_digits !== exp_d) begin n_bad++; $display("FAIL ar_digits %0d got %h want %h", i, b_digits, exp_d); end
      n_cmp++; if (b_done !== (i == 2)) begin n_bad++; $display("FAIL ar_done %0d got %b want %b", i, b_done, i == 2); end
      n_cmp++; if (b_running !== 1'b1) begin n_bad++; $display("FAIL ar_running %0d got %b want 1", i, b_running); end
    end
    b_reset = 1'b1; b_tick_en = 1'b1; b_start = 1'b1; cyc();
    b_reset = 1'b0; b_tick_en = 1'b0; b_start = 1'b0;
    n_cmp++; if (b_digits !== 16'h0000 || b_running !== 1'b0 || b_zero !== 1'b1 || b_done !== 1'b0) begin
      n_bad++; $display("FAIL ar_reset got %h run %b zero %b done %b want 0000 0 1 0", b_digits, b_running, b_zero, b_done);
    end
  endtask

  initial begin
    reset = 1'b1; tick_en = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; preset = '0;
    b_reset = 1'b1; b_tick_en = 1'b0; b_load = 1'b0; b_start = 1'b0; b_stop = 1'b0; b_preset = '0;
    cyc(); cyc();
    b_reset = 1'b0;
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_start_tick();
    test_auto_reload();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
